core_run_ctrl: RTL and testbench

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_core_run_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_run_ctrl
// Purpose  : Holds a core cluster in reset, releases cores on a stagger,
//            supervises the run for completion or timeout.
// Revision : 1.0  initial release
// ============================================================================
module core_run_ctrl #(
    parameter int NUM_CORES       = 2,
    parameter int RST_HOLD_CYCLES = 2,
    parameter int STAGGER_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES  = 30,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_CORES-1:0] halt_req,
    output logic [NUM_CORES-1:0] core_rst_n,
    output logic [NUM_CORES-1:0] core_halted,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RESET_HOLD = 3'd1,
        S_RELEASE    = 3'd2,
        S_RUN        = 3'd3,
        S_DONE       = 3'd4,
        S_TIMEOUT    = 3'd5
    } state_t;

    localparam logic [31:0]      c_hold_last = 32'(RST_HOLD_CYCLES - 1);
    localparam logic [31:0]      c_rel_last  = 32'((NUM_CORES - 1) * STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    logic [31:0]          r_cnt;
    logic [NUM_CORES-1:0] r_core_rst_n;
    logic [NUM_CORES-1:0] r_halted;
    logic [CNT_W-1:0]     r_cycle_count;
    logic                 r_running;
    logic                 r_done;
    logic                 r_timeout;

    logic [31:0]          w_rel_idx;
    logic [NUM_CORES-1:0] w_rel_mask;
    logic [NUM_CORES-1:0] w_halted_next;
    logic                 w_all_halted;

    // Release offset of the cycle being entered: 0 on RELEASE entry, k+1 while in RELEASE.
    assign w_rel_idx = (r_state == S_RELEASE) ? (r_cnt + 32'd1) : 32'd0;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_rel
            assign w_rel_mask[gi] = (32'(gi * STAGGER_CYCLES) <= w_rel_idx);
        end
    endgenerate

    // A halt request only counts for a core that is already out of reset.
    assign w_halted_next = ((r_state == S_RELEASE) || (r_state == S_RUN))
                         ? (r_halted | (halt_req & r_core_rst_n))
                         : r_halted;
    assign w_all_halted  = &w_halted_next;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_core_rst_n  <= '0;
            r_halted      <= '0;
            r_cycle_count <= '0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        r_state       <= S_RESET_HOLD;
                        r_cnt         <= '0;
                        r_core_rst_n  <= '0;
                        r_halted      <= '0;
                        r_cycle_count <= '0;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end
                S_RESET_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        r_state      <= S_RELEASE;
                        r_cnt        <= '0;
                        r_core_rst_n <= w_rel_mask;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_RELEASE: begin
                    r_halted <= w_halted_next;
                    if (r_cnt == c_rel_last) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else begin
                        r_cnt        <= r_cnt + 32'd1;
                        r_core_rst_n <= w_rel_mask;
                    end
                end
                S_RUN: begin
                    r_halted <= w_halted_next;
                    if (r_cycle_count != c_cnt_max) begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                    // Completion is checked first so a last-cycle halt beats the timeout.
                    if (w_all_halted) begin
                        r_state      <= S_DONE;
                        r_running    <= 1'b0;
                        r_done       <= 1'b1;
                        r_core_rst_n <= '0;
                    end else if (r_cycle_count == c_to_last) begin
                        r_state      <= S_TIMEOUT;
                        r_running    <= 1'b0;
                        r_timeout    <= 1'b1;
                        r_core_rst_n <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_rst_n  = r_core_rst_n;
    assign core_halted = r_halted;
    assign running     = r_running;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_run_ctrl
// Purpose  : Scoreboard bench for core_run_ctrl; expected output events come
//            from a schedule-level model of each run.
// Revision : 1.0  initial release
// ============================================================================
module tb_core_run_ctrl;

    localparam int N    = 2;
    localparam int H    = 2;
    localparam int S    = 1;
    localparam int T    = 30;
    localparam int W    = 16;
    localparam int NONE = -1000;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         start    = 1'b0;
    logic         abort    = 1'b0;
    logic [N-1:0] halt_req = '0;
    logic [N-1:0] core_rst_n;
    logic [N-1:0] core_halted;
    logic         running;
    logic         done;
    logic         timeout;
    logic [W-1:0] cycle_count;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [N-1:0] rst_n;
        logic         running;
        logic         done;
        logic         timeout;
        logic [W-1:0] count;
        logic [N-1:0] halted;
    } obs_t;

    obs_t           exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc    = 0;
    bit             mon_en = 1'b0;
    logic [2*N+2:0] mon_key   = '0;
    logic [2*N+2:0] model_key = '0;
    int             prel[N][2];

    core_run_ctrl #(
        .NUM_CORES       (N),
        .RST_HOLD_CYCLES (H),
        .STAGGER_CYCLES  (S),
        .TIMEOUT_CYCLES  (T),
        .CNT_W           (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .halt_req    (halt_req),
        .core_rst_n  (core_rst_n),
        .core_halted (core_halted),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*N+2:0] key_of(input obs_t o);
        return {o.rst_n, o.running, o.done, o.timeout, o.halted};
    endfunction

    // Every change of the control/flag outputs is an event to be matched.
    always @(negedge clk) begin
        obs_t cur;
        obs_t e;
        if (mon_en) begin
            cur.cyc     = 32'(cyc);
            cur.rst_n   = core_rst_n;
            cur.running = running;
            cur.done    = done;
            cur.timeout = timeout;
            cur.count   = cycle_count;
            cur.halted  = core_halted;
            if (key_of(cur) !== mon_key) begin
                mon_key = key_of(cur);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d: rst_n=%b run=%b done=%b to=%b cnt=%0d halted=%b, required no change",
                             cur.cyc, cur.rst_n, cur.running, cur.done, cur.timeout, cur.count, cur.halted);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d rst_n=%b run=%b done=%b to=%b cnt=%0d halted=%b, required cyc=%0d rst_n=%b run=%b done=%b to=%b cnt=%0d halted=%b",
                                 cur.cyc, cur.rst_n, cur.running, cur.done, cur.timeout, cur.count, cur.halted,
                                 e.cyc, e.rst_n, e.running, e.done, e.timeout, e.count, e.halted);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p(input int a0, input int a1, input int b0, input int b1);
        prel[0][0] = a0;
        prel[0][1] = a1;
        prel[1][0] = b0;
        prel[1][1] = b1;
    endtask

    // prel holds halt pulse cycles relative to the first RUN cycle; cut_off is
    // the abort/rst cycle relative to the start cycle (-1 for none).
    task automatic run_seq(input int cut_off, input bit cut_is_rst, input bit noisy);
        int   s, r, u, e_end, stop, a, f, fin, p;
        int   eff[N];
        bit   all_h;
        obs_t o;
        s     = cyc;
        r     = s + H + 1;
        u     = r + (N - 1) * S + 1;
        all_h = 1'b1;
        f     = 0;
        for (int i = 0; i < N; i++) begin
            eff[i] = NONE;
            for (int k = 0; k < 2; k++) begin
                if (prel[i][k] != NONE) begin
                    p = u + prel[i][k];
                    if (p >= r + i * S && p <= u + T - 1 && (eff[i] == NONE || p < eff[i]))
                        eff[i] = p;
                end
            end
            if (eff[i] == NONE) all_h = 1'b0;
            else if (eff[i] > f) f = eff[i];
        end
        e_end = all_h ? (((f > u) ? f : u) + 1) : (u + T);
        fin   = e_end - u;
        a     = (cut_off >= 0) ? s + cut_off : NONE;
        stop  = (a != NONE) ? a + 1 : e_end;

        for (int c = s + 1; c <= stop; c++) begin
            o     = '0;
            o.cyc = 32'(c);
            if (a != NONE && c > a) begin
                o.cyc = 32'(c);
            end else if (c >= e_end) begin
                o.done    = all_h;
                o.timeout = !all_h;
                o.count   = W'(fin);
                for (int i = 0; i < N; i++) o.halted[i] = (eff[i] != NONE && eff[i] < e_end);
            end else begin
                for (int i = 0; i < N; i++) o.halted[i] = (eff[i] != NONE && eff[i] < c);
                if (c >= u) begin
                    o.rst_n   = '1;
                    o.running = 1'b1;
                    o.count   = W'(c - u);
                end else begin
                    for (int i = 0; i < N; i++) o.rst_n[i] = (c >= r + i * S);
                end
            end
            if (key_of(o) != model_key) begin
                exp_q.push_back(o);
                model_key = key_of(o);
            end
        end

        for (int c = s; c < stop; c++) begin
            start = (c == s) || (noisy && c < e_end && $urandom_range(0, 3) == 0);
            abort = !cut_is_rst && (c == a);
            rst   = cut_is_rst && (c == a);
            for (int i = 0; i < N; i++) begin
                halt_req[i] = 1'b0;
                for (int k = 0; k < 2; k++)
                    if (prel[i][k] != NONE && u + prel[i][k] == c) halt_req[i] = 1'b1;
            end
            tick();
        end
        start    = 1'b0;
        abort    = 1'b0;
        rst      = 1'b0;
        halt_req = '0;
        repeat ($urandom_range(1, 3)) begin
            halt_req = N'($urandom);
            tick();
        end
        halt_req = '0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cut;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({core_rst_n, core_halted, running, done, timeout, cycle_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rst_n=%b halted=%b run=%b done=%b to=%b cnt=%0d, required all zero",
                     core_rst_n, core_halted, running, done, timeout, cycle_count);
        end
        mon_key   = '0;
        model_key = '0;
        mon_en    = 1'b1;
        tick();

        set_p(4, NONE, 9, NONE);        run_seq(-1, 1'b0, 1'b0);
        set_p(NONE, NONE, NONE, NONE);  run_seq(-1, 1'b0, 1'b1);
        set_p(3, NONE, 29, NONE);       run_seq(-1, 1'b0, 1'b0);
        set_p(NONE, NONE, NONE, NONE);  run_seq(3, 1'b0, 1'b0);
        set_p(2, NONE, -4, NONE);       run_seq(-1, 1'b0, 1'b0);
        set_p(-2, NONE, -1, NONE);      run_seq(-1, 1'b0, 1'b0);
        set_p(1, NONE, NONE, NONE);     run_seq(10, 1'b1, 1'b0);
        set_p(5, NONE, 6, NONE);        run_seq(-1, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                prel[i][0] = int'($urandom_range(0, T + 6)) - 2;
                prel[i][1] = ($urandom_range(0, 1) == 1) ? -int'($urandom_range(1, 5)) : NONE;
            end
            cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1;
            run_seq(cut, 1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d unmatched expected events, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
